// File: rtl/mode_select_if.sv
// mode_select_if - button/display bundle between the board front end and
// the display top.
//   KEY         : raw active-low push buttons (driven by the board side)
//   PB          : registered mode code (110 hex, 101 BCD, 011 decimal)
//   enable      : registered display enable
//   mode_strobe : one-cycle pulse when PB changes value
interface mode_select_if;
    logic [3:0] KEY;
    logic [2:0] PB;
    logic       enable;
    logic       mode_strobe;

    modport master (output KEY, input PB, enable, mode_strobe);
    modport slave  (input KEY, output PB, enable, mode_strobe);
endinterface

// File: rtl/mode_select.sv
// mode_select - front end of the display path. Four raw active-low buttons
// are synchronised, debounced and press-edge detected. KEY[2:0] select the
// display mode (lowest index wins), KEY[3] toggles the display enable.
//   Clock  : system clock, rising edge
//   Resetn : asynchronous active-low reset
//   bus    : mode_select_if.slave (KEY in; PB, enable, mode_strobe out)

// One button lane: 2-flop synchroniser, run-length debounce, press detect.
//   key_i   : raw active-low key, asynchronous to Clock
//   press_o : one-cycle pulse per debounced 1->0 transition
module mode_select_lane #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic key_i,
    output logic press_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q, sync_q;
    logic             stable_q, stable_d;
    logic             stable_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronised level disagrees with the
    // accepted level; any agreement throws the partial count away.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_LAST)
                stable_d = sync_q;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            meta_q       <= 1'b1;
            sync_q       <= 1'b1;
            stable_q     <= 1'b1;
            stable_dly_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            meta_q       <= key_i;
            sync_q       <= meta_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
        end
    end

    // Falling edge of the debounced level = press (buttons are active-low).
    assign press_o = stable_dly_q & ~stable_q;
endmodule

module mode_select #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic          Clock,
    input  logic          Resetn,
    mode_select_if.slave  bus
);
    typedef enum logic [2:0] {
        MODE_HEX = 3'b110,
        MODE_BCD = 3'b101,
        MODE_DEC = 3'b011
    } mode_e;

    logic [3:0] press;
    mode_e      pb_q, pb_d;
    logic       en_q, en_d;
    logic       strobe_q, strobe_d;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        mode_select_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_lane (
            .Clock   (Clock),
            .Resetn  (Resetn),
            .key_i   (bus.KEY[gi]),
            .press_o (press[gi])
        );
    end

    // Mode keys resolve lowest index first; the enable key is independent
    // and may act on the same edge as a mode change.
    always_comb begin
        pb_d = pb_q;
        if (press[0])
            pb_d = MODE_HEX;
        else if (press[1])
            pb_d = MODE_BCD;
        else if (press[2])
            pb_d = MODE_DEC;
        en_d     = en_q ^ press[3];
        strobe_d = (pb_d != pb_q);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pb_q     <= MODE_HEX;
            en_q     <= 1'b1;
            strobe_q <= 1'b0;
        end else begin
            pb_q     <= pb_d;
            en_q     <= en_d;
            strobe_q <= strobe_d;
        end
    end

    assign bus.PB          = pb_q;
    assign bus.enable      = en_q;
    assign bus.mode_strobe = strobe_q;
endmodule

// File: tb/tb_mode_select.sv
module tb_mode_select;
    localparam int DC = 4;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;
    mode_select_if bus ();

    int checks   = 0;
    int failures = 0;

    mode_select #(.DEBOUNCE_CYCLES(DC)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    // ---------------- behavioural model ----------------
    // A key's accepted level flips once the last DC synchronised samples
    // (the raw key two edges late) all disagree with it. A flip to 0 is a
    // press, which reaches the outputs one edge later.
    bit       hist [4][DC];
    bit       stab [4];
    bit       pend [4];
    bit       q1   [4];
    bit       q2   [4];
    logic [2:0] m_pb;
    bit       m_en;
    bit       m_st;

    initial begin
        logic [2:0] npb;
        bit         all_diff;
        forever begin
            @(posedge Clock or negedge Resetn);
            if (!Resetn) begin
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < DC; j++) hist[i][j] = 1'b1;
                    stab[i] = 1'b1; pend[i] = 1'b0; q1[i] = 1'b1; q2[i] = 1'b1;
                end
                m_pb = 3'b110; m_en = 1'b1; m_st = 1'b0;
            end else begin
                npb = m_pb;
                if (pend[0])      npb = 3'b110;
                else if (pend[1]) npb = 3'b101;
                else if (pend[2]) npb = 3'b011;
                m_st = (npb != m_pb);
                m_pb = npb;
                if (pend[3]) m_en = !m_en;
                for (int i = 0; i < 4; i++) begin
                    for (int j = DC - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
                    hist[i][0] = q2[i];
                    all_diff = 1'b1;
                    for (int j = 0; j < DC; j++)
                        if (hist[i][j] == stab[i]) all_diff = 1'b0;
                    pend[i] = 1'b0;
                    if (all_diff) begin
                        stab[i] = !stab[i];
                        pend[i] = !stab[i];
                    end
                end
                for (int i = 0; i < 4; i++) begin
                    q2[i] = q1[i];
                    q1[i] = bus.KEY[i];
                end
            end
        end
    end

    // Per-cycle compare, well after the stimulus settles.
    initial begin
        forever begin
            @(negedge Clock);
            #2;
            checks++;
            if (bus.PB !== m_pb || bus.enable !== m_en || bus.mode_strobe !== m_st) begin
                failures++;
                $display("FAIL model t=%0t got PB=%b en=%b st=%b exp PB=%b en=%b st=%b",
                         $time, bus.PB, bus.enable, bus.mode_strobe, m_pb, m_en, m_st);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic outs(input string name, input logic [2:0] pb, input logic en, input logic st);
        chk({name, "_pb"}, {29'd0, bus.PB}, {29'd0, pb});
        chk({name, "_en"}, {31'd0, bus.enable}, {31'd0, en});
        chk({name, "_st"}, {31'd0, bus.mode_strobe}, {31'd0, st});
    endtask

    // ---------------- stimulus ----------------
    int hold [4];

    initial begin
        bus.KEY = 4'hF;
        step(3);
        outs("reset", 3'b110, 1'b1, 1'b0);
        Resetn = 1'b1;
        step(20);
        outs("idle", 3'b110, 1'b1, 1'b0);

        // KEY[1] held: update DC+2 edges after the first low sample.
        bus.KEY = ~4'b0010;
        step(6);
        outs("k1_pre", 3'b110, 1'b1, 1'b0);
        step(1);
        outs("k1_hit", 3'b101, 1'b1, 1'b1);
        step(1);
        outs("k1_after", 3'b101, 1'b1, 1'b0);
        step(10);
        bus.KEY = 4'hF;
        step(12);
        outs("k1_rel", 3'b101, 1'b1, 1'b0);

        // KEY[2] bounce (3 low, 1 high, 3 low) must be rejected.
        bus.KEY = ~4'b0100; step(3);
        bus.KEY = 4'hF;     step(1);
        bus.KEY = ~4'b0100; step(3);
        bus.KEY = 4'hF;     step(10);
        outs("bounce", 3'b101, 1'b1, 1'b0);
        bus.KEY = ~4'b0100;
        step(6);
        outs("k2_pre", 3'b101, 1'b1, 1'b0);
        step(1);
        outs("k2_hit", 3'b011, 1'b1, 1'b1);
        bus.KEY = 4'hF; step(12);

        // Back to BCD, then KEY[0]+KEY[2] together: KEY[0] wins.
        bus.KEY = ~4'b0010; step(7);
        outs("k1_again", 3'b101, 1'b1, 1'b1);
        bus.KEY = 4'hF; step(12);
        bus.KEY = ~4'b0101; step(7);
        outs("k02_hit", 3'b110, 1'b1, 1'b1);
        bus.KEY = 4'hF; step(12);
        bus.KEY = ~4'b0001; step(7);
        outs("k0_same", 3'b110, 1'b1, 1'b0);
        bus.KEY = 4'hF; step(12);

        // Enable toggle alongside a mode change, then alone.
        bus.KEY = ~4'b1010; step(7);
        outs("k31_hit", 3'b101, 1'b0, 1'b1);
        bus.KEY = 4'hF; step(12);
        bus.KEY = ~4'b1000; step(7);
        outs("k3_hit", 3'b101, 1'b1, 1'b0);
        bus.KEY = 4'hF; step(12);

        // Reset mid-debounce with KEY[1] still held.
        bus.KEY = ~4'b0010; step(3);
        Resetn = 1'b0; #1;
        outs("rst_mid", 3'b110, 1'b1, 1'b0);
        step(1);
        Resetn = 1'b1;
        step(6);
        outs("rst_pre", 3'b110, 1'b1, 1'b0);
        step(1);
        outs("rst_hit", 3'b101, 1'b1, 1'b1);
        bus.KEY = 4'hF; step(12);

        // Random key activity with occasional resets, checked by the model.
        for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 14);
        for (int c = 0; c < 4000; c++) begin
            step(1);
            for (int i = 0; i < 4; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    bus.KEY[i] = ~bus.KEY[i];
                    hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 30)
                                                          : $urandom_range(1, 6);
                end
            end
            if ($urandom_range(0, 499) == 0) begin
                Resetn = 1'b0;
                step($urandom_range(1, 2));
                Resetn = 1'b1;
            end
        end
        bus.KEY = 4'hF;
        step(20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
